// File: rtl/fifo_level.sv
// fifo_level: single-clock show-ahead FIFO with occupancy count,
// almost-full/almost-empty threshold flags and sticky overflow/underflow flags.
module fifo_level #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int AFULL_THR  = (2 ** ADDR_WIDTH) - 2,
  parameter int AEMPTY_THR = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  err_clr,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  rd,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  localparam logic [ADDR_WIDTH:0] PTR_ONE    = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT  = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] AFULL_CNT  = AFULL_THR[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AEMPTY_CNT = AEMPTY_THR[ADDR_WIDTH:0];

  // Threshold ordering is checked while the design is elaborated.
  generate
    if (!(AEMPTY_THR > 0 && AEMPTY_THR < AFULL_THR && AFULL_THR <= DEPTH)) begin : g_param_check
      $error("fifo_level: thresholds must satisfy 0 < AEMPTY_THR < AFULL_THR <= DEPTH");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0] count_q, count_d;
  logic                overflow_q, overflow_d;
  logic                underflow_q, underflow_d;

  logic wr_accept;
  logic rd_accept;
  logic mem_we;

  // Status flags come only from the registered count, never from wr/rd.
  always_comb begin
    full         = (count_q == DEPTH_CNT);
    empty        = (count_q == '0);
    almost_full  = (count_q >= AFULL_CNT);
    almost_empty = (count_q <= AEMPTY_CNT);
    count        = count_q;
    overflow     = overflow_q;
    underflow    = underflow_q;
    r_data       = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
  end

  // Next-state for pointers, count and sticky error flags; flush overrides traffic.
  always_comb begin
    wr_accept   = wr && (!full || rd);
    rd_accept   = rd && !empty;
    mem_we      = wr_accept && !flush;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q && !err_clr;
    underflow_d = underflow_q && !err_clr;

    if (wr && full && !rd) begin
      overflow_d = 1'b1;
    end
    if (rd && empty && !wr) begin
      underflow_d = 1'b1;
    end

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_accept) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (rd_accept) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      case ({wr_accept, rd_accept})
        2'b10:   count_d = count_q + PTR_ONE;
        2'b01:   count_d = count_q - PTR_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers, cleared asynchronously on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array is not reset; accepted writes land at the write pointer.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= w_data;
    end
  end

endmodule

// File: tb/tb_fifo_level.sv
// tb_fifo_level: randomized and directed stimulus against a queue-based
// reference model, with a scoreboard monitor checking every word read out.
module tb_fifo_level;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AFULL = DEPTH - 2;
  localparam int AEMPT = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          err_clr = 1'b0;
  logic          wr = 1'b0;
  logic [DW-1:0] w_data = '0;
  logic          rd = 1'b0;
  logic [DW-1:0] r_data;
  logic          full, empty, almost_full, almost_empty;
  logic [AW:0]   count;
  logic          overflow, underflow;

  int tests = 0;
  int fails = 0;

  // Reference model: plain queue of stored words plus sticky flags.
  logic [DW-1:0] model_q[$];
  logic          model_ovf = 1'b0;
  logic          model_unf = 1'b0;

  // Scoreboard of words expected on accepted reads.
  logic [DW-1:0] exp_q[$];

  fifo_level #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .AFULL_THR(AFULL),
    .AEMPTY_THR(AEMPT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .flush(flush),
    .err_clr(err_clr),
    .wr(wr),
    .w_data(w_data),
    .rd(rd),
    .r_data(r_data),
    .full(full),
    .empty(empty),
    .almost_full(almost_full),
    .almost_empty(almost_empty),
    .count(count),
    .overflow(overflow),
    .underflow(underflow)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a word being read.
  always @(negedge clk) begin
    if (rst_n && rd && !flush && !empty) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL read_unexpected: got %0h expected no read at %0t", r_data, $time);
      end else begin
        checkVal("read_data", {24'h0, r_data}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  // Compares all registered outputs against the model after an edge.
  task automatic checkOutput();
    int n;
    n = model_q.size();
    checkVal("count", {27'h0, count}, n);
    checkVal("full", {31'h0, full}, {31'h0, (n == DEPTH)});
    checkVal("empty", {31'h0, empty}, {31'h0, (n == 0)});
    checkVal("almost_full", {31'h0, almost_full}, {31'h0, (n >= AFULL)});
    checkVal("almost_empty", {31'h0, almost_empty}, {31'h0, (n <= AEMPT)});
    checkVal("overflow", {31'h0, overflow}, {31'h0, model_ovf});
    checkVal("underflow", {31'h0, underflow}, {31'h0, model_unf});
    if (n > 0) begin
      checkVal("head", {24'h0, r_data}, {24'h0, model_q[0]});
    end
  endtask

  // Drives one cycle of inputs, updates the model, and checks after the edge.
  task automatic applyStimulus(input logic w, input logic r, input logic [DW-1:0] d,
                               input logic fl, input logic ec);
    bit is_full, is_empty;
    wr      = w;
    rd      = r;
    w_data  = d;
    flush   = fl;
    err_clr = ec;
    is_full  = (model_q.size() == DEPTH);
    is_empty = (model_q.size() == 0);
    if (ec) begin
      model_ovf = 1'b0;
      model_unf = 1'b0;
    end
    if (w && is_full && !r) model_ovf = 1'b1;
    if (r && is_empty && !w) model_unf = 1'b1;
    if (fl) begin
      model_q.delete();
    end else begin
      if (r && !is_empty) begin
        exp_q.push_back(model_q[0]);
        void'(model_q.pop_front());
      end
      if (w && (!is_full || r)) model_q.push_back(d);
    end
    @(posedge clk);
    #1;
    wr      = 1'b0;
    rd      = 1'b0;
    flush   = 1'b0;
    err_clr = 1'b0;
    checkOutput();
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    model_q.delete();
    exp_q.delete();
    model_ovf = 1'b0;
    model_unf = 1'b0;
    #2;
    checkVal("reset_count", {27'h0, count}, 32'd0);
    checkVal("reset_empty", {31'h0, empty}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    int written;
    logic w, r;
    #3;
    doReset();

    // Fill 0x01..0x10 without reads.
    for (int i = 1; i <= DEPTH; i++) applyStimulus(1'b1, 1'b0, DW'(i), 1'b0, 1'b0);

    // Full: simultaneous read and write keeps count, stores 0xAA.
    applyStimulus(1'b1, 1'b1, 8'hAA, 1'b0, 1'b0);
    // Full: write only overflows, then clear.
    applyStimulus(1'b1, 1'b0, 8'hEE, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    // Drain all; 0xAA comes out last.
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);

    // Empty: read underflows; read+write with 0x55 stores the word.
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'h55, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
    // Error event coinciding with err_clr: set wins.
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    // 40 words with interleaved reads, occupancy kept within 3..10.
    written = 0;
    for (int cyc = 0; cyc < 400 && written < 40; cyc++) begin
      if (model_q.size() < 3) begin
        w = 1'b1; r = 1'b0;
      end else if (model_q.size() >= 10) begin
        w = 1'b0; r = 1'b1;
      end else begin
        w = 1'($urandom_range(0, 1));
        r = 1'($urandom_range(0, 1));
      end
      if (w) written++;
      applyStimulus(w, r, DW'($urandom), 1'b0, 1'b0);
    end
    while (model_q.size() > 0) applyStimulus(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);

    // Count 7 then flush with a concurrent write.
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b0, DW'($urandom), 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h77, 1'b1, 1'b0);

    // Count 5 then asynchronous reset mid-operation.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, DW'($urandom), 1'b0, 1'b0);
    doReset();

    // Random traffic with occasional error clears and flushes.
    for (int cyc = 0; cyc < 600; cyc++) begin
      w = 1'($urandom_range(0, 99) < 55);
      r = 1'($urandom_range(0, 99) < 45);
      applyStimulus(w, r, DW'($urandom), 1'($urandom_range(0, 99) == 0),
                    1'($urandom_range(0, 19) == 0));
    end

    @(negedge clk);
    checkVal("scoreboard_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_level.md
FIFO_LEVEL -- requirements
Module: fifo_level

Interface
REQ-001 Parameter DATA_WIDTH, 8, word width in bits.
REQ-002 Parameter ADDR_WIDTH, 4, address width; depth DEPTH = 2**ADDR_WIDTH.
REQ-003 Parameter AFULL_THR, DEPTH-2, almost_full threshold in words.
REQ-004 Parameter AEMPTY_THR, 2, almost_empty threshold in words.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 flush  input  1  synchronous clear of stored contents.
REQ-008 err_clr  input  1  synchronous clear of sticky error flags.
REQ-009 wr  input  1  write request.
REQ-010 w_data  input  DATA_WIDTH  write data.
REQ-011 rd  input  1  read request; acknowledges the current r_data word.
REQ-012 r_data  output  DATA_WIDTH  head-of-queue word (show-ahead).
REQ-013 full, empty  output  1 each  occupancy == DEPTH, occupancy == 0.
REQ-014 almost_full, almost_empty  output  1 each  threshold flags.
REQ-015 count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
REQ-016 overflow, underflow  output  1 each  sticky error flags.

Function
REQ-017 Storage SHALL be a DEPTH-entry register array with ADDR_WIDTH+1-bit read/write pointers; extra MSB distinguishes full from empty; pointers wrap modulo 2*DEPTH.
REQ-018 r_data SHALL combinationally present mem[rd_ptr] (zero-latency show-ahead); value undefined while empty.
REQ-019 Write accepted when wr && (!full || rd): word stored at wr_ptr, wr_ptr+1 at the clock edge.
REQ-020 Read accepted when rd && !empty: rd_ptr+1 at the clock edge.
REQ-021 Simultaneous accepted read and write SHALL leave count unchanged, including when full (full stays 1, head advances, new word stored in vacated slot).
REQ-022 Simultaneous rd && wr when empty: write accepted, read ignored, count becomes 1, underflow not set.
REQ-023 count SHALL be registered, updated in the same edge as pointers: +1 write-only, -1 read-only, unchanged otherwise; never exceeds DEPTH or goes below 0.
REQ-024 full, empty, almost_full, almost_empty SHALL be derived from registered state only (no combinational path from wr/rd).
REQ-025 almost_full = (count >= AFULL_THR); almost_empty = (count <= AEMPTY_THR).
REQ-026 overflow SHALL set on edge where wr && full && !rd; underflow on edge where rd && empty && !wr; both hold until err_clr or reset; rejected operations SHALL not alter pointers or memory.
REQ-027 err_clr SHALL clear both error flags; if a new error event coincides with err_clr, the flag SHALL be set (set wins).
REQ-028 flush SHALL set wr_ptr = rd_ptr = 0 and count = 0 on the next edge, overriding wr/rd in that cycle; memory contents need not be cleared; error flags unaffected.
REQ-029 Parameters SHALL satisfy 0 < AEMPTY_THR < AFULL_THR <= DEPTH; violation SHALL be flagged at elaboration.

Reset
REQ-030 On rst_n low, asynchronously: pointers = 0, count = 0, empty = 1, almost_empty = 1, full = 0, almost_full = 0, overflow = 0, underflow = 0; memory not reset.
REQ-031 Reset asserted mid-operation SHALL discard all contents; first cycle after release behaves as empty FIFO.

Verification
REQ-032 Defaults, write 0x01..0x10 (16 words) without reads -> count 16, full=1, almost_full from count 14, r_data = 0x01 throughout.
REQ-033 From full, wr=1 rd=1 with w_data=0xAA -> count stays 16, full stays 1, r_data advances to 0x02, 0xAA read out as 16th word after draining.
REQ-034 From full, wr=1 rd=0 -> overflow=1, count 16, contents unchanged; err_clr pulse -> overflow=0.
REQ-035 From empty, rd=1 -> underflow=1, count 0; rd=1 wr=1 with 0x55 -> count 1, r_data=0x55, no new underflow.
REQ-036 Write 40 words with interleaved reads keeping count 3..10 -> output order matches input order across pointer wrap; almost_empty toggles at count 2/3.
REQ-037 Count 7, flush=1 with wr=1 -> next cycle count 0, empty=1; rst_n pulsed low at count 5 -> immediate empty=1, count 0.
